branch_predictor_bht: RTL and testbench

//  Fetch-side branch predictor; the prediction end of branch resolution. Fetch looks up PC and gets a

---
 rtl/branch_predictor_bht_pkg.sv | 28 ++
 rtl/bht_sat_counter.sv | 22 ++
 rtl/branch_predictor_bht.sv | 127 ++++++++++++
 tb/tb_branch_predictor_bht.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_bht_pkg.sv
// rtl/branch_predictor_bht_pkg.sv - shared constants and entry types for the fetch-side branch predictor
package branch_predictor_bht_pkg;

    localparam int XLEN  = 32;
    localparam int CTR_W = 2;

    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;

    // Per-entry state that carries a reset value; tag and target live in separate plain arrays
    // because their widths follow the top-level parameters and they never need clearing.
    typedef struct packed {
        logic             valid;
        logic             jump;
        logic [CTR_W-1:0] ctr;
    } bht_meta_t;

    localparam bht_meta_t META_RESET = '{valid: 1'b0, jump: 1'b0, ctr: CTR_RESET};

    function automatic logic is_ctl_op(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// rtl/bht_sat_counter.sv - 2-bit saturating up/down counter, next-state only
module bht_sat_counter
    import branch_predictor_bht_pkg::*;
(
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    output logic [CTR_W-1:0] ctr_next
);

    // Step toward strongly-taken on inc, strongly-not-taken otherwise, holding at the ends
    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != 2'b11) begin
                ctr_next = ctr + 2'd1;
            end
        end else if (ctr != 2'b00) begin
            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - direct-mapped BTB with 2-bit counters, mispredict redirect and statistics
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [XLEN-1:0]  f_pc,
    output logic             f_predTaken,
    output logic [XLEN-1:0]  f_predTarget,
    input  logic             u_valid,
    input  logic [XLEN-1:0]  u_pc,
    input  logic [6:0]       u_opCode,
    input  logic             u_taken,
    input  logic [XLEN-1:0]  u_target,
    input  logic             u_predTaken,
    input  logic [XLEN-1:0]  u_predTarget,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_meta_t       meta_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             f_hit;
    logic             u_ctl;
    logic             u_hit;
    logic             m_d;
    logic [CTR_W-1:0] ctr_next;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = u_pc[IDX_W+1:2];
    assign u_tag = u_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Fetch lookup reads the registered table only, so a same-cycle update is not visible yet
    always_comb begin
        f_hit        = meta_q[f_idx].valid && (tag_q[f_idx] == f_tag);
        f_predTaken  = f_hit && (meta_q[f_idx].jump || meta_q[f_idx].ctr[1]);
        f_predTarget = f_predTaken ? target_q[f_idx] : (f_pc + 32'd4);
    end

    // Resolve-side decode: which updates count, which hit, and whether fetch guessed wrong
    always_comb begin
        u_ctl = u_valid && is_ctl_op(u_opCode);
        u_hit = meta_q[u_idx].valid && (tag_q[u_idx] == u_tag);
        m_d   = u_ctl && ((u_predTaken != u_taken) ||
                          (u_taken && (u_predTarget != u_target)));
    end

    bht_sat_counter u_ctr (
        .ctr      (meta_q[u_idx].ctr),
        .inc      (u_taken),
        .ctr_next (ctr_next)
    );

    // Valid/jump/counter state: clear wins over a same-cycle update, and a not-taken miss leaves the table alone
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_q[i] <= META_RESET;
            end
        end else if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                meta_q[i].valid <= 1'b0;
            end
        end else if (u_ctl) begin
            if (u_hit) begin
                meta_q[u_idx].ctr <= ctr_next;
            end else if (u_taken) begin
                meta_q[u_idx] <= '{valid: 1'b1,
                                   jump:  (u_opCode != OP_BRANCH),
                                   ctr:   CTR_ALLOC};
            end
        end
    end

    // Tag and target payload; only meaningful behind a set valid bit, so no reset is needed
    always_ff @(posedge clock) begin
        if (!clear && u_ctl && u_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= u_target;
        end
    end

    // Registered redirect pulse; redirect_pc holds its last value between mispredicts
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= m_d;
            if (m_d) begin
                redirect_pc <= u_taken ? u_target : (u_pc + 32'd4);
            end
        end
    end

    // Saturating statistics, unaffected by clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (u_ctl && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (m_d && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - scoreboard bench for the branch predictor against a table-level reference model
module tb_branch_predictor_bht;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic [31:0] f_pc;
    logic        f_predTaken;
    logic [31:0] f_predTarget;
    logic        u_valid;
    logic [31:0] u_pc;
    logic [6:0]  u_opCode;
    logic        u_taken;
    logic [31:0] u_target;
    logic        u_predTaken;
    logic [31:0] u_predTarget;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    branch_predictor_bht dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .f_pc         (f_pc),
        .f_predTaken  (f_predTaken),
        .f_predTarget (f_predTarget),
        .u_valid      (u_valid),
        .u_pc         (u_pc),
        .u_opCode     (u_opCode),
        .u_taken      (u_taken),
        .u_target     (u_target),
        .u_predTaken  (u_predTaken),
        .u_predTarget (u_predTarget),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc),
        .branch_cnt   (branch_cnt),
        .miss_cnt     (miss_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: 16 entries, tag = pc[13:6], index = pc[5:2]
    bit          mv   [16];
    bit          mj   [16];
    int          mtag [16];
    logic [31:0] mtgt [16];
    int          mctr [16];
    int          exp_bcnt;
    int          exp_mcnt;

    typedef struct {
        logic [31:0] rpc;
        int          bc;
        int          mc;
    } ev_t;
    ev_t evq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0; mj[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 1;
        end
        exp_bcnt = 0;
        exp_mcnt = 0;
        evq.delete();
    endtask

    task automatic model_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
        int i;
        int t;
        i  = int'(pc[5:2]);
        t  = int'(pc[13:6]);
        tk = mv[i] && (mtag[i] == t) && (mj[i] || mctr[i] >= 2);
        tgt = tk ? mtgt[i] : pc + 32'd4;
    endtask

    // Sets inputs at the falling edge, checks the combinational lookup, then applies the model at the rising edge
    task automatic drive(input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                         input logic [6:0] op, input bit tk, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt, input bit clr);
        bit          e_tk;
        logic [31:0] e_tgt;
        bit          ctl;
        bit          hit;
        bit          m;
        int          i;
        int          t;
        f_pc = fpc; u_valid = uv; u_pc = upc; u_opCode = op; u_taken = tk;
        u_target = tgt; u_predTaken = ptk; u_predTarget = ptgt; clear = clr;
        #1;
        model_lookup(fpc, e_tk, e_tgt);
        check("f_predTaken", {31'd0, f_predTaken}, {31'd0, e_tk});
        check("f_predTarget", f_predTarget, e_tgt);
        @(posedge clock);
        ctl = uv && (op == 7'h63 || op == 7'h6F || op == 7'h67);
        if (ctl) begin
            i   = int'(upc[5:2]);
            t   = int'(upc[13:6]);
            hit = mv[i] && (mtag[i] == t);
            m   = (ptk != tk) || (tk && ptgt != tgt);
            if (!clr) begin
                if (hit) begin
                    mctr[i] = tk ? ((mctr[i] < 3) ? mctr[i] + 1 : 3) : ((mctr[i] > 0) ? mctr[i] - 1 : 0);
                    if (tk) mtgt[i] = tgt;
                end else if (tk) begin
                    mv[i] = 1; mj[i] = (op != 7'h63); mtag[i] = t; mtgt[i] = tgt; mctr[i] = 2;
                end
            end
            if (exp_bcnt < 65535) exp_bcnt++;
            if (m) begin
                ev_t ev;
                if (exp_mcnt < 65535) exp_mcnt++;
                ev.rpc = tk ? tgt : upc + 32'd4;
                ev.bc  = exp_bcnt;
                ev.mc  = exp_mcnt;
                evq.push_back(ev);
            end
        end
        if (clr) begin
            for (int k = 0; k < 16; k++) mv[k] = 0;
        end
        @(negedge clock);
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(fpc, 0, 32'h0, 7'h00, 0, 32'h0, 0, 32'h0, 0);
    endtask

    // Monitor: every mispredict pulse must match the oldest queued expectation, and no expected pulse may go missing
    always @(negedge clock) begin
        if (reset_n) begin
            if (mispredict) begin
                if (evq.size() == 0) begin
                    check("unexpected_mispredict", 32'd1, 32'd0);
                end else begin
                    ev_t ev;
                    ev = evq.pop_front();
                    check("redirect_pc", redirect_pc, ev.rpc);
                    check("miss_cnt@pulse", {16'd0, miss_cnt}, ev.mc[31:0]);
                    check("branch_cnt@pulse", {16'd0, branch_cnt}, ev.bc[31:0]);
                end
            end else if (evq.size() != 0) begin
                check("missing_mispredict", 32'd0, 32'd1);
                evq.delete();
            end
        end
    end

    logic [6:0] ops [4];

    initial begin
        ops[0] = 7'h63; ops[1] = 7'h6F; ops[2] = 7'h67; ops[3] = 7'h33;
        reset_n = 0; clear = 0; f_pc = 32'h100; u_valid = 0; u_pc = 0; u_opCode = 0;
        u_taken = 0; u_target = 0; u_predTaken = 0; u_predTarget = 0;
        model_reset();
        #1;
        check("reset_predTaken", {31'd0, f_predTaken}, 32'd0);
        check("reset_predTarget", f_predTarget, 32'h104);
        check("reset_mispredict", {31'd0, mispredict}, 32'd0);
        check("reset_redirect", redirect_pc, 32'd0);
        check("reset_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        check("reset_miss_cnt", {16'd0, miss_cnt}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1;
        @(negedge clock);

        // Taken beq allocates and mispredicts
        drive(32'h100, 1, 32'h100, 7'h63, 1, 32'h80, 0, 32'h104, 0);
        check("miss_cnt_after_first", {16'd0, miss_cnt}, 32'd1);
        idle(32'h100);
        // Two not-takens then four takens then one not-taken
        drive(32'h100, 1, 32'h100, 7'h63, 0, 32'h80, 1, 32'h80, 0);
        drive(32'h100, 1, 32'h100, 7'h63, 0, 32'h80, 1, 32'h80, 0);
        idle(32'h100);
        for (int k = 0; k < 4; k++) drive(32'h100, 1, 32'h100, 7'h63, 1, 32'h80, 0, 32'h104, 0);
        drive(32'h100, 1, 32'h100, 7'h63, 0, 32'h80, 1, 32'h80, 0);
        idle(32'h100);

        // jal allocates a jump entry; an aliasing PC with another tag misses
        drive(32'h40, 1, 32'h40, 7'h6F, 1, 32'h200, 0, 32'h44, 0);
        drive(32'h40, 1, 32'h40, 7'h63, 0, 32'h200, 1, 32'h200, 0);
        drive(32'h40, 1, 32'h40, 7'h63, 0, 32'h200, 1, 32'h200, 0);
        idle(32'h40);
        idle(32'h80);

        // Same-index lookup during update sees old contents; clear drops a same-cycle allocation
        drive(32'h100, 1, 32'h100, 7'h63, 0, 32'h80, 1, 32'h80, 0);
        drive(32'h300, 1, 32'h300, 7'h67, 1, 32'h700, 0, 32'h304, 1);
        idle(32'h300);
        idle(32'h40);
        idle(32'h100);
        check("branch_cnt_after_clear", {16'd0, branch_cnt}, exp_bcnt[31:0]);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] upc, fpc, tgt, ptgt;
            bit tk, ptk, clr;
            upc  = {18'd0, 8'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'b00};
            fpc  = ($urandom_range(0, 2) == 0) ? upc
                 : {18'd0, 8'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'b00};
            tgt  = {$urandom_range(0, 65535) * 4};
            tk   = 1'($urandom_range(0, 1));
            ptk  = 1'($urandom_range(0, 1));
            ptgt = ($urandom_range(0, 3) != 0) ? tgt : upc + 32'd4;
            clr  = ($urandom_range(0, 49) == 0);
            drive(fpc, 1'($urandom_range(0, 4) != 0), upc, ops[$urandom_range(0, 3)],
                  tk, tgt, ptk, ptgt, clr);
        end

        // Non-control opcode with a wrong prediction changes nothing
        drive(32'h100, 1, 32'h100, 7'h33, 1, 32'h900, 0, 32'h104, 0);
        check("nonctl_branch_cnt", {16'd0, branch_cnt}, exp_bcnt[31:0]);
        check("nonctl_miss_cnt", {16'd0, miss_cnt}, exp_mcnt[31:0]);

        // Drive branch_cnt into saturation
        while (exp_bcnt < 65534) begin
            drive(32'h500, 1, 32'h500, 7'h63, 0, 32'h0, 0, 32'h504, 0);
        end
        check("branch_cnt_fffe", {16'd0, branch_cnt}, 32'h0000FFFE);
        for (int k = 0; k < 3; k++) drive(32'h500, 1, 32'h500, 7'h63, 0, 32'h0, 0, 32'h504, 0);
        check("branch_cnt_sat", {16'd0, branch_cnt}, 32'h0000FFFF);

        // Asynchronous reset in the middle of an update, right after a mispredict pulse
        drive(32'h600, 1, 32'h600, 7'h6F, 1, 32'h1000, 0, 32'h604, 0);
        f_pc = 32'h600; u_valid = 1; u_pc = 32'h600; u_opCode = 7'h63; u_taken = 1;
        u_target = 32'h2000; u_predTaken = 0; u_predTarget = 32'h604;
        #2;
        reset_n = 0;
        #1;
        check("async_mispredict", {31'd0, mispredict}, 32'd0);
        check("async_redirect", redirect_pc, 32'd0);
        check("async_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        check("async_miss_cnt", {16'd0, miss_cnt}, 32'd0);
        check("async_predTaken", {31'd0, f_predTaken}, 32'd0);
        check("async_predTarget", f_predTarget, 32'h604);
        model_reset();
        @(negedge clock);
        u_valid = 0;
        reset_n = 1;
        @(negedge clock);
        idle(32'h600);
        idle(32'h100);

        if (evq.size() != 0) check("leftover_events", evq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
